// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI mode-0 master sequencing load/shift/load transactions
module spi_master_ctrl #(
  parameter int WIDTH   = 13,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             miso,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             sclk,
  output logic             mosi,
  output logic             load
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BITS    = CNT_W'(WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SHIFT, S_POST, S_DONE} state_t;

  state_t           state, state_d;
  logic [DIV_W-1:0] div_cnt, div_d;
  logic             phase, phase_d;
  logic [CNT_W-1:0] bit_cnt, bit_d;
  logic [WIDTH-1:0] tx_sr, tx_d, rx_sr, rx_sr_d, rx_data_d;
  logic             sclk_d, mosi_d, load_d, busy_d, done_d;
  logic             tick;

  assign tick = (div_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      div_cnt <= '0;
      phase   <= 1'b0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      load    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
    end else begin
      state   <= state_d;
      div_cnt <= div_d;
      phase   <= phase_d;
      bit_cnt <= bit_d;
      tx_sr   <= tx_d;
      rx_sr   <= rx_sr_d;
      sclk    <= sclk_d;
      mosi    <= mosi_d;
      load    <= load_d;
      busy    <= busy_d;
      done    <= done_d;
      rx_data <= rx_data_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (start) state_d = S_PRE;
      S_PRE:   if (tick && phase) state_d = S_SHIFT;
      S_SHIFT: if (tick && phase && bit_cnt == BITS) state_d = S_POST;
      S_POST:  if (tick && phase) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Each state is two halves (phase 0/1) of CLK_DIV cycles; the divider reloads at every half boundary.
  always_comb begin
    div_d     = div_cnt;
    phase_d   = phase;
    bit_d     = bit_cnt;
    tx_d      = tx_sr;
    rx_sr_d   = rx_sr;
    sclk_d    = sclk;
    mosi_d    = mosi;
    load_d    = load;
    busy_d    = busy;
    done_d    = 1'b0;
    rx_data_d = rx_data;
    if (state != S_IDLE && state != S_DONE) begin
      div_d = tick ? DIV_MAX : div_cnt - DIV_W'(1);
      if (tick) phase_d = ~phase;
    end
    case (state)
      S_IDLE: begin
        if (start) begin
          tx_d    = tx_data;
          mosi_d  = tx_data[WIDTH-1];
          load_d  = 1'b1;
          busy_d  = 1'b1;
          div_d   = DIV_MAX;
          phase_d = 1'b0;
          bit_d   = '0;
        end
      end
      S_PRE: begin
        if (tick) begin
          if (!phase) begin
            load_d = 1'b0;
          end else begin
            sclk_d  = 1'b1;
            rx_sr_d = {rx_sr[WIDTH-2:0], miso};
          end
        end
      end
      S_SHIFT: begin
        if (tick) begin
          if (!phase) begin
            sclk_d = 1'b0;
            tx_d   = {tx_sr[WIDTH-2:0], 1'b0};
            mosi_d = tx_sr[WIDTH-2];
            bit_d  = bit_cnt + CNT_W'(1);
          end else if (bit_cnt == BITS) begin
            load_d = 1'b1;
          end else begin
            sclk_d  = 1'b1;
            rx_sr_d = {rx_sr[WIDTH-2:0], miso};
          end
        end
      end
      S_POST: begin
        if (tick) begin
          if (!phase) begin
            load_d = 1'b0;
          end else begin
            done_d    = 1'b1;
            rx_data_d = rx_sr;
            busy_d    = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

endmodule
